// File: rtl/mario_motion.sv
// Per-frame Mario position and jump controller.
// It turns a USB HID keycode into walking, a single-shot jump and gravity-driven falling.
module mario_motion #(
  parameter int X_Min      = 0,
  parameter int X_Max      = 639,
  parameter int Y_Min      = 0,
  parameter int Ground_Y   = 400,
  parameter int Start_X    = 100,
  parameter int Mario_Size = 15,
  parameter int Walk_Step  = 2,
  parameter int Jump_V     = 12,
  parameter int Gravity    = 1,
  parameter int Max_Fall   = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [9:0] MarioX,
  output logic [9:0] MarioY,
  output logic [9:0] MarioS,
  output logic [1:0] Mario_State,
  output logic       Facing_Left
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_RISE   = 2'b01,
    ST_FALL   = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  // 11-bit working width keeps every clamp comparison free of wrap-around.
  localparam logic [10:0] C_X_LO   = 11'(X_Min + Mario_Size);
  localparam logic [10:0] C_X_HI   = 11'(X_Max - Mario_Size);
  localparam logic [10:0] C_Y_TOP  = 11'(Y_Min + Mario_Size);
  localparam logic [10:0] C_GROUND = 11'(Ground_Y);
  localparam logic [10:0] C_WALK   = 11'(Walk_Step);
  localparam logic [10:0] C_GRAV   = 11'(Gravity);
  localparam logic [10:0] C_MAXF   = 11'(Max_Fall);

  state_t      r_state, w_state_next;
  logic [9:0]  r_x, w_x_next;
  logic [9:0]  r_y, w_y_next;
  logic [4:0]  r_vy, w_vy_next;
  logic        r_facing, w_facing_next;
  logic        r_jump_prev;

  logic        w_left, w_right, w_jump, w_jump_edge;
  logic [10:0] w_x11, w_y11, w_vy11, w_vn11;

  assign w_left      = (keycode == 8'h04);
  assign w_right     = (keycode == 8'h07);
  assign w_jump      = (keycode == 8'h2C) || (keycode == 8'h1A);
  assign w_jump_edge = w_jump && !r_jump_prev;

  assign w_x11  = {1'b0, r_x};
  assign w_y11  = {1'b0, r_y};
  assign w_vy11 = {6'b0, r_vy};
  assign w_vn11 = (w_vy11 + C_GRAV > C_MAXF) ? C_MAXF : (w_vy11 + C_GRAV);

  // NOTE: every output of this block is given a default first, so no path can hold a value and infer a latch.
  always_comb begin
    w_x_next      = r_x;
    w_facing_next = r_facing;
    if (w_left) begin
      w_x_next      = (w_x11 < C_X_LO + C_WALK) ? C_X_LO[9:0] : (r_x - C_WALK[9:0]);
      w_facing_next = 1'b1;
    end else if (w_right) begin
      w_x_next      = (w_x11 + C_WALK > C_X_HI) ? C_X_HI[9:0] : (r_x + C_WALK[9:0]);
      w_facing_next = 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_y;
    w_vy_next    = r_vy;
    case (r_state)
      ST_GROUND: begin
        if (w_jump_edge) begin
          w_state_next = ST_RISE;
          w_vy_next    = 5'(Jump_V);
        end else begin
          w_vy_next = 5'd0;
          w_y_next  = C_GROUND[9:0];
        end
      end
      ST_RISE: begin
        // Ceiling test is written as Y < top + vy so it cannot underflow.
        if (w_y11 < C_Y_TOP + w_vy11) begin
          w_y_next     = C_Y_TOP[9:0];
          w_vy_next    = 5'd0;
          w_state_next = ST_FALL;
        end else begin
          w_y_next = r_y - {5'b0, r_vy};
          if (w_vy11 <= C_GRAV) begin
            w_vy_next    = 5'd0;
            w_state_next = ST_FALL;
          end else begin
            w_vy_next = r_vy - C_GRAV[4:0];
          end
        end
      end
      ST_FALL: begin
        if (w_y11 + w_vn11 >= C_GROUND) begin
          w_y_next     = C_GROUND[9:0];
          w_vy_next    = 5'd0;
          w_state_next = ST_GROUND;
        end else begin
          w_y_next  = r_y + {5'b0, w_vn11[4:0]};
          w_vy_next = w_vn11[4:0];
        end
      end
      default: begin
        w_vy_next    = 5'd0;
        w_state_next = ST_FALL;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_GROUND;
      r_x         <= 10'(Start_X);
      r_y         <= C_GROUND[9:0];
      r_vy        <= 5'd0;
      r_facing    <= 1'b0;
      r_jump_prev <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_vy        <= w_vy_next;
      r_facing    <= w_facing_next;
      r_jump_prev <= w_jump;
    end
  end

  assign MarioX      = r_x;
  assign MarioY      = r_y;
  assign MarioS      = 10'(Mario_Size);
  assign Mario_State = r_state;
  assign Facing_Left = r_facing;

endmodule

// File: tb/tb_mario_motion.sv
// Scoreboard bench for mario_motion: the driver queues hand-computed per-frame expectations.
// The monitor pops one expectation and compares it after each clock edge or reset assertion.
module tb_mario_motion;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] MarioX, MarioY, MarioS;
  logic [1:0] Mario_State;
  logic       Facing_Left;

  mario_motion dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .MarioX     (MarioX),
    .MarioY     (MarioY),
    .MarioS     (MarioS),
    .Mario_State(Mario_State),
    .Facing_Left(Facing_Left)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    s;
    int    f;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int rise_y[12] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322};
  int fall_y[14] = '{323, 325, 328, 332, 337, 343, 350, 358, 366, 374, 382, 390, 398, 400};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int ex, input int ey, input int es, input int ef);
    exp_t e;
    e.tag = tag;
    e.x   = ex;
    e.y   = ey;
    e.s   = es;
    e.f   = ef;
    sb.push_back(e);
  endtask

  // A negative expectation field means "not checked on this frame".
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk or posedge Reset);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.x >= 0) check({e.tag, "_x"}, int'(MarioX), e.x);
        if (e.y >= 0) check({e.tag, "_y"}, int'(MarioY), e.y);
        if (e.s >= 0) check({e.tag, "_state"}, int'(Mario_State), e.s);
        if (e.f >= 0) check({e.tag, "_facing"}, int'(Facing_Left), e.f);
        check({e.tag, "_size"}, int'(MarioS), 15);
      end
    end
  end

  task automatic frame(input logic rst, input logic [7:0] key, input string tag,
                       input int ex, input int ey, input int es, input int ef);
    @(negedge frame_clk);
    Reset   = rst;
    keycode = key;
    @(posedge frame_clk);
    push_exp(tag, ex, ey, es, ef);
  endtask

  task automatic async_reset(input string tag);
    @(negedge frame_clk);
    #2;
    push_exp(tag, 100, 400, 0, 0);
    Reset = 1'b1;
  endtask

  task automatic do_jump(input logic [7:0] kp, input logic [7:0] ka, input int x0,
                         input int dx, input int f0, input int f1);
    frame(1'b0, kp, "jump_edge", x0, 400, 1, f0);
    for (int i = 0; i < 12; i++)
      frame(1'b0, ka, $sformatf("rise%0d", i), x0 + dx * (i + 1), rise_y[i], (i == 11) ? 2 : 1, f1);
    for (int i = 0; i < 14; i++)
      frame(1'b0, ka, $sformatf("fall%0d", i), x0 + dx * (i + 13), fall_y[i], (i == 13) ? 0 : 2, f1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, queue depth %0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    int ex;
    Reset   = 1'b0;
    keycode = 8'h00;
    #2;
    push_exp("reset_async", 100, 400, 0, 0);
    Reset = 1'b1;

    frame(1'b1, 8'h07, "reset_held", 100, 400, 0, 0);

    for (int i = 0; i < 10; i++)
      frame(1'b0, 8'h00, $sformatf("idle%0d", i), 100, 400, 0, 0);

    do_jump(8'h2C, 8'h00, 100, 0, 0, 0);
    frame(1'b0, 8'h00, "after_jump", 100, 400, 0, 0);

    // Held space: one jump, then grounded until the key is released.
    do_jump(8'h2C, 8'h2C, 100, 0, 0, 0);
    for (int i = 0; i < 33; i++)
      frame(1'b0, 8'h2C, $sformatf("held_ground%0d", i), 100, 400, 0, 0);
    frame(1'b0, 8'h00, "held_release", 100, 400, 0, 0);

    // W triggers a jump; walking left while airborne.
    do_jump(8'h1A, 8'h04, 100, -2, 0, 1);

    // Jump again, then reset while falling at Y = 350.
    frame(1'b0, 8'h2C, "rj_edge", 48, 400, 1, 1);
    for (int i = 0; i < 12; i++)
      frame(1'b0, 8'h00, $sformatf("rj_rise%0d", i), 48, rise_y[i], (i == 11) ? 2 : 1, 1);
    for (int i = 0; i < 7; i++)
      frame(1'b0, 8'h00, $sformatf("rj_fall%0d", i), 48, fall_y[i], 2, 1);
    async_reset("reset_midfall");
    frame(1'b1, 8'h2C, "reset_midfall_held", 100, 400, 0, 0);
    frame(1'b0, 8'h00, "post_reset0", 100, 400, 0, 0);
    frame(1'b0, 8'h00, "post_reset1", 100, 400, 0, 0);

    // Walk left from the start column into the left wall at 15.
    async_reset("reset_walk");
    for (int k = 1; k <= 60; k++) begin
      ex = 100 - 2 * k;
      if (ex < 15) ex = 15;
      frame(1'b0, 8'h04, $sformatf("left%0d", k), ex, 400, 0, 1);
    end

    // Walk right from 15 up to 623, then into the right wall at 624.
    for (int k = 1; k <= 307; k++) begin
      ex = 15 + 2 * k;
      if (ex > 624) ex = 624;
      frame(1'b0, 8'h07, $sformatf("right%0d", k), ex, 400, 0, 0);
    end

    frame(1'b0, 8'h05, "other_key", 624, 400, 0, 0);
    frame(1'b0, 8'h04, "left_from_wall", 622, 400, 0, 1);
    frame(1'b0, 8'h07, "right_to_wall", 624, 400, 0, 0);

    @(negedge frame_clk);
    @(negedge frame_clk);
    check("scoreboard_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mario_motion.md
MARIO_MOTION -- requirements
Module: mario_motion

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- X_Min, 0, leftmost screen column
- X_Max, 639, rightmost screen column
- Y_Min, 0, topmost screen row
- Ground_Y, 400, Mario centre row when standing
- Start_X, 100, Mario centre column after reset
- Mario_Size, 15, half-width of the Mario sprite
- Walk_Step, 2, horizontal pixels per frame
- Jump_V, 12, initial upward speed in pixels per frame
- Gravity, 1, speed change per frame
- Max_Fall, 8, terminal downward speed

REQ-002 Ports (name, direction, width, meaning), one per line:
- frame_clk  in  1  frame-rate clock; one update per rising edge
- Reset  in  1  asynchronous, active-high
- keycode  in  8  current USB HID keycode; 0x00 means no key
- MarioX  out  10  sprite centre column
- MarioY  out  10  sprite centre row
- MarioS  out  10  constant Mario_Size
- Mario_State  out  2  00 GROUND, 01 RISE, 10 FALL
- Facing_Left  out  1  1 after the last horizontal move was leftward

REQ-003 Reset is asynchronous and active-high; the clock is frame_clk; all state updates on the rising edge of frame_clk.

Function
REQ-004 Keycode decode:
- 0x04 (A): left
- 0x07 (D): right
- 0x2C (space) or 0x1A (W): jump
- Any other value: no action
REQ-005 The jump edge condition is true only when jump is decoded this frame and jump_prev=0; jump_prev is registered from the jump decode every frame in every state.
REQ-006 Horizontal motion, independent of vertical state:
- Left: MarioX <= max(MarioX-Walk_Step, X_Min+Mario_Size); Facing_Left <= 1
- Right: MarioX <= min(MarioX+Walk_Step, X_Max-Mario_Size); Facing_Left <= 0
- Otherwise: MarioX and Facing_Left hold
REQ-007 All comparisons and the clamp arithmetic use at least 11-bit intermediates so that no subtraction wraps below 0.
REQ-008 The vertical speed register vy is 5-bit unsigned.
REQ-009 GROUND state:
- Jump edge: next state RISE, vy <= Jump_V, MarioY unchanged this frame
- Otherwise: vy <= 0 and MarioY <= Ground_Y
REQ-010 RISE state, each frame:
- MarioY <= MarioY - vy, using the pre-edge vy; vy <= vy - Gravity
- If vy - Gravity = 0: next state FALL
REQ-011 RISE ceiling: if MarioY - vy < Y_Min + Mario_Size, then MarioY <= Y_Min + Mario_Size, vy <= 0, and the next state is FALL.
REQ-012 FALL state, each frame:
- vn = min(vy + Gravity, Max_Fall); vy <= vn
- If MarioY + vn >= Ground_Y: MarioY <= Ground_Y, vy <= 0, next state GROUND
- Otherwise: MarioY <= MarioY + vn
REQ-013 Jump keys in RISE or FALL are ignored and do not queue.
REQ-014 A jump key held through landing does not retrigger a jump.
REQ-015 Walking is permitted in every state.
REQ-016 Mario_State is the encoding of the registered state; the unused code 11 forces the next state to FALL with vy <= 0.
REQ-017 Outputs are registered directly; there is no combinational path from keycode to any output.

Reset
REQ-018 While Reset is high, regardless of frame_clk:
- MarioX = Start_X (100)
- MarioY = Ground_Y (400)
- vy = 0, state GROUND, Facing_Left = 0, jump_prev = 0
- MarioS = 15
REQ-019 Reset asserted mid-jump returns Mario to (100, 400) and GROUND immediately, with no residual velocity after release.

Verification
REQ-020 Reset released with keycode 0x00 for 10 frames -> MarioX = 100, MarioY = 400, Mario_State = 00 on every frame.
REQ-021 One frame of 0x2C, then 0x00:
- Edge frame: RISE, Y = 400
- 12 RISE frames: Y = 388, 377, …, 322, then FALL
- 14 FALL frames: Y = 323, 325, 328, 332, 337, 343, 350, 358, 366, 374, 382, 390, 398, 400
- Final frame: GROUND
REQ-022 0x2C held for 60 frames -> exactly one jump; after landing, Mario stays in GROUND at Y = 400 until the key is released and pressed again.
REQ-023 Keycode 0x04 held from reset for 60 frames -> MarioX = 98, 96, …, reaches 15, then holds at 15; Facing_Left = 1.
REQ-024 Keycode 0x07 held with MarioX = 623 -> MarioX = 624, then holds at 624.
REQ-025 Reset pulsed during FALL at Y = 350 -> on the next frame after release, Y = 400, state GROUND, vy = 0.
